luma_line_buffer: RTL and testbench
===================================

LUMA_LINE_BUFFER -- requirements
Module: luma_line_buffer

Interface
REQ-001 SHALL have parameter NPIX, default 152, number of rendered pixels per line.
REQ-002 SHALL have parameter H_DIV, default 8, clk48 cycles per rendered pixel.
REQ-003 SHALL have parameter H_TOTAL, default 1525, and V_TOTAL, default 525, scan totals in clocks and lines.
REQ-004 SHALL have port clk48, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports h_count and v_count, inputs, 11 and 10 bits, from the display timing counters.
REQ-007 SHALL have ports wr_valid (input, 1), wr_ready (output, 1) and wr_data (input, 7: bit 6 visible, bits 5:0 luma), the renderer write handshake.
REQ-008 SHALL have ports line_req (output, 1, one-cycle pulse) and line_y (output, 10), the renderer start request and the line to render.
REQ-009 SHALL have ports donut_luma (output, 6) and donut_visible (output, 1), the pixel feed to the palette/dither stage.
REQ-010 SHALL have port underrun (output, 1), a sticky flag.

Function
REQ-011 SHALL hold two banks of NPIX x 7-bit entries: front (read) and back (write).
REQ-012 Write FSM SHALL have states FILL, FULL; wr_ready=1 only in FILL.
REQ-013 A beat SHALL transfer when wr_valid and wr_ready are both 1; it writes back[wr_ptr] and increments wr_ptr.
REQ-014 The transfer at wr_ptr==NPIX-1 SHALL move FILL->FULL and leave wr_ptr at 0.
REQ-015 The swap point SHALL be h_count==H_TOTAL-1.
REQ-016 At the swap point in FULL: banks swap; state -> FILL; line_req pulses on the next cycle; line_y=(v_count+2) mod V_TOTAL.
REQ-017 At the swap point in FILL: no swap; front repeats; underrun set to 1; wr_ptr and state unchanged.
REQ-018 When a final beat (wr_ptr==NPIX-1) coincides with the swap point, the beat SHALL be written and the swap SHALL occur in that same cycle.
REQ-019 Read index SHALL reset to 0 with its sub-counter at the swap point and SHALL advance by one every H_DIV clocks.
REQ-020 Read index SHALL saturate at NPIX-1.
REQ-021 Outputs SHALL be registered with 1-cycle latency from h_count.
REQ-022 donut_visible SHALL be 0 when the index has reached NPIX (sub-counter wrapped past NPIX-1) or no swap has yet occurred.

Reset
REQ-023 rst SHALL force state FILL, wr_ptr 0, wr_ready 1, line_req 0, line_y 0, donut_luma 0, donut_visible 0, underrun 0, and the front bank invalid.
REQ-024 Bank contents SHALL NOT be reset.
REQ-025 Reset asserted mid-fill SHALL discard the partial line.
REQ-026 The first line_req after reset SHALL occur only after a full back bank is swapped; the renderer starts its first line on wr_ready alone, and that line is numbered 0.

Configuration
REQ-027 Macro LINEBUF_VDOUBLE_EN: when defined, the swap point SHALL be qualified by v_count[0]==1, so each rendered line is shown on two scanlines, and line_y SHALL be (v_count+3) mod V_TOTAL with bit 0 cleared.
REQ-028 Without LINEBUF_VDOUBLE_EN, the block SHALL swap on every line as in REQ-016.
REQ-029 Underrun under LINEBUF_VDOUBLE_EN SHALL be evaluated only at qualified swap points.

Structure
REQ-030 Shared package vgadonut_pkg SHALL hold the H_TOTAL and V_TOTAL timing constants and a luma_pix_t typedef (visible + 6-bit luma).
REQ-031 Each bank SHALL be implemented by sub-module linebuf_bank (1 write port, 1 registered read port).

Verification
REQ-032 After reset, 152 beats with wr_valid held at 1 -> wr_ready drops after beat 152; at h_count=1524, line_req pulses one cycle later with line_y=(v_count+2).
REQ-033 Entry k=luma k mod 64, visible=1 -> at h_count=8k+1, donut_luma=k mod 64 and donut_visible=1; at h_count=1300, donut_visible=0.
REQ-034 Only 100 beats before the swap point -> underrun=1, previous line repeated, wr_ptr continues from 100.
REQ-035 Final beat presented exactly at h_count=1524 -> the beat is written and the swap occurs the same cycle; new front entry 151 is correct.
REQ-036 rst pulsed at wr_ptr=70 -> all outputs return to their reset values; wr_ready=1; donut_visible=0 until the next full swap.
REQ-037 With LINEBUF_VDOUBLE_EN, lines v=10 and v=11 -> both show identical pixels; swap only at end of v=11.

Source files
------------

// File: rtl/vgadonut_pkg.sv
// vgadonut_pkg: shared display-timing constants and pixel types for the
// VGA donut pipeline.
//   VGA_H_TOTAL / VGA_V_TOTAL : scan totals (clk48 cycles per line, lines per frame)
//   luma_pix_t                : {visible, luma[5:0]} as produced by the renderer
//   wr_state_t                : line-buffer write FSM states
package vgadonut_pkg;

    localparam int unsigned VGA_H_TOTAL = 1525;
    localparam int unsigned VGA_V_TOTAL = 525;
    localparam int unsigned LUMA_W      = 6;

    typedef struct packed {
        logic              visible;
        logic [LUMA_W-1:0] luma;
    } luma_pix_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wr_state_t;

endpackage

// File: rtl/linebuf_bank.sv
// linebuf_bank: one line bank of DEPTH luma_pix_t entries.
//   i_clk            : clock
//   i_rst            : async active-high reset (read register only; contents are not reset)
//   i_we/i_waddr/i_wdata : write port
//   i_raddr          : read address
//   o_rdata          : registered read data (one-cycle latency)
module linebuf_bank
    import vgadonut_pkg::*;
#(
    parameter int unsigned DEPTH = 152,
    parameter int unsigned AW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  luma_pix_t     i_wdata,
    input  logic [AW-1:0] i_raddr,
    output luma_pix_t     o_rdata
);

    luma_pix_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/luma_line_buffer.sv
// luma_line_buffer: ping-pong line buffer between the donut renderer and the
// palette/dither stage. The renderer fills the back bank through a valid/ready
// handshake; at the end of each scanline a full back bank becomes the front
// bank, which is replayed at one entry per H_DIV clocks.
//   clk48, rst          : clock, async active-high reset
//   h_count, v_count    : display timing counters
//   wr_valid/wr_ready/wr_data : renderer write handshake ({visible, luma})
//   line_req, line_y    : one-cycle request to render line line_y
//   donut_luma/donut_visible : pixel feed, one cycle after h_count
//   underrun            : sticky, set when a line end finds the back bank unfinished
// Build option: define LINEBUF_VDOUBLE_EN to show each rendered line on two
// scanlines (swap only at the end of odd scanlines).
module luma_line_buffer
    import vgadonut_pkg::*;
#(
    parameter int unsigned NPIX    = 152,
    parameter int unsigned H_DIV   = 8,
    parameter int unsigned H_TOTAL = VGA_H_TOTAL,
    parameter int unsigned V_TOTAL = VGA_V_TOTAL
) (
    input  logic        clk48,
    input  logic        rst,
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [6:0]  wr_data,
    output logic        line_req,
    output logic [9:0]  line_y,
    output logic [5:0]  donut_luma,
    output logic        donut_visible,
    output logic        underrun
);

    localparam int unsigned   AW       = (NPIX  > 1) ? $clog2(NPIX)  : 1;
    localparam int unsigned   SW       = (H_DIV > 1) ? $clog2(H_DIV) : 1;
    localparam logic [AW-1:0] LAST     = AW'(NPIX - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(H_DIV - 1);

    wr_state_t     r_state;
    logic [AW-1:0] r_wr_ptr;
    logic          r_wr_ready;
    logic          r_line_req;
    logic [9:0]    r_line_y;
    logic          r_underrun;
    logic          r_front;
    logic          r_front_valid;
    logic [AW-1:0] r_rd_idx;
    logic [SW-1:0] r_sub;
    logic          r_past;
    logic          r_sel;
    logic          r_vis_ok;

    luma_pix_t     w_wdata;
    luma_pix_t     w_q0;
    luma_pix_t     w_q1;
    luma_pix_t     w_pix;
    logic          w_beat;
    logic          w_last_beat;
    logic          w_line_end;
    logic          w_swap_pt;
    logic          w_swap;
    logic [10:0]   w_ly_sum;
    logic [9:0]    w_line_y_next;

    assign w_wdata     = luma_pix_t'(wr_data);
    assign w_beat      = wr_valid & r_wr_ready;
    assign w_last_beat = w_beat & (r_wr_ptr == LAST);
    assign w_line_end  = (h_count == 11'(H_TOTAL - 1));

`ifdef LINEBUF_VDOUBLE_EN
    assign w_swap_pt = w_line_end & v_count[0];
    assign w_ly_sum  = {1'b0, v_count} + 11'd3;
`else
    assign w_swap_pt = w_line_end;
    assign w_ly_sum  = {1'b0, v_count} + 11'd2;
`endif

    // A final beat arriving on the swap point completes the bank in time.
    assign w_swap = w_swap_pt & ((r_state == FULL) | w_last_beat);

    always_comb begin
        w_line_y_next = (w_ly_sum >= 11'(V_TOTAL)) ? 10'(w_ly_sum - 11'(V_TOTAL))
                                                   : w_ly_sum[9:0];
`ifdef LINEBUF_VDOUBLE_EN
        w_line_y_next[0] = 1'b0;
`endif
    end

    // Write FSM with registered handshake and request outputs.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            r_state       <= FILL;
            r_wr_ptr      <= '0;
            r_wr_ready    <= 1'b1;
            r_line_req    <= 1'b0;
            r_line_y      <= '0;
            r_underrun    <= 1'b0;
            r_front       <= 1'b0;
            r_front_valid <= 1'b0;
        end else begin
            r_line_req <= 1'b0;
            if (w_beat) begin
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_swap) begin
                r_state       <= FILL;
                r_wr_ready    <= 1'b1;
                r_front       <= ~r_front;
                r_front_valid <= 1'b1;
                r_line_req    <= 1'b1;
                r_line_y      <= w_line_y_next;
            end else if (w_last_beat) begin
                r_state    <= FULL;
                r_wr_ready <= 1'b0;
            end else if (w_swap_pt && (r_state == FILL)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Read side restarts on every line end, so an unswapped front is replayed.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            r_rd_idx <= '0;
            r_sub    <= '0;
            r_past   <= 1'b1;
            r_sel    <= 1'b0;
            r_vis_ok <= 1'b0;
        end else begin
            if (w_line_end) begin
                r_rd_idx <= '0;
                r_sub    <= '0;
                r_past   <= 1'b0;
            end else if (r_sub == SUB_LAST) begin
                r_sub <= '0;
                if (r_rd_idx == LAST) begin
                    r_past <= 1'b1;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end else begin
                r_sub <= r_sub + 1'b1;
            end
            // Aligned with the bank read registers.
            r_sel    <= r_front;
            r_vis_ok <= r_front_valid & ~r_past;
        end
    end

    linebuf_bank #(.DEPTH(NPIX), .AW(AW)) u_bank0 (
        .i_clk   (clk48),
        .i_rst   (rst),
        .i_we    (w_beat & r_front),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_idx),
        .o_rdata (w_q0)
    );

    linebuf_bank #(.DEPTH(NPIX), .AW(AW)) u_bank1 (
        .i_clk   (clk48),
        .i_rst   (rst),
        .i_we    (w_beat & ~r_front),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_idx),
        .o_rdata (w_q1)
    );

    assign w_pix         = r_sel ? w_q1 : w_q0;
    assign wr_ready      = r_wr_ready;
    assign line_req      = r_line_req;
    assign line_y        = r_line_y;
    assign underrun      = r_underrun;
    assign donut_luma    = w_pix.luma;
    assign donut_visible = w_pix.visible & r_vis_ok;

endmodule

// File: tb/tb_luma_line_buffer.sv
// tb_luma_line_buffer: directed self-checking bench for luma_line_buffer.
// Drives a model of the timing counters and a renderer that streams
// {1, (k + tag) mod 64} for entry k of each line.
module tb_luma_line_buffer;

    localparam int NPIX    = 152;
    localparam int H_DIV   = 8;
    localparam int H_TOTAL = 1525;
    localparam int V_TOTAL = 525;

    logic        clk48;
    logic        rst;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        wr_valid;
    logic        wr_ready;
    logic [6:0]  wr_data;
    logic        line_req;
    logic [9:0]  line_y;
    logic [5:0]  donut_luma;
    logic        donut_visible;
    logic        underrun;

    luma_line_buffer #(
        .NPIX    (NPIX),
        .H_DIV   (H_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) dut (
        .clk48         (clk48),
        .rst           (rst),
        .h_count       (h_count),
        .v_count       (v_count),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .line_req      (line_req),
        .line_y        (line_y),
        .donut_luma    (donut_luma),
        .donut_visible (donut_visible),
        .underrun      (underrun)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    int n_cmp = 0;
    int n_bad = 0;

    // renderer model
    int rk     = 0;
    int rlimit = 0;
    int rtag   = 0;
    bit rhold  = 1'b0;

    typedef struct {
        int h;
        int luma;
        int vis;
    } pix_vec_t;

    pix_vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (v=%0d h=%0d)",
                     name, act, exp, v_count, h_count);
        end
    endtask

    task automatic drive_src();
        if (rst || rk >= rlimit)
            wr_valid = 1'b0;
        else if (rhold && rk == NPIX - 1 && h_count != 11'(H_TOTAL - 1))
            wr_valid = 1'b0;
        else
            wr_valid = 1'b1;
        wr_data = {1'b1, 6'((rk + rtag) % 64)};
    endtask

    // One clock; returns 1 time unit after the rising edge with inputs updated.
    task automatic tick();
        bit xfer;
        xfer = wr_valid && wr_ready && !rst;
        @(posedge clk48);
        #1;
        if (xfer) rk++;
        if (h_count == 11'(H_TOTAL - 1)) begin
            h_count = '0;
            v_count = (v_count == 10'(V_TOTAL - 1)) ? '0 : v_count + 1'b1;
        end else begin
            h_count = h_count + 1'b1;
        end
        drive_src();
    endtask

    task automatic start_line(input int tag, input int limit);
        rtag   = tag;
        rlimit = limit;
        rk     = 0;
        drive_src();
    endtask

    task automatic wait_vh(input int v, input int h, input string name);
        int n;
        n = 0;
        while (!(int'(v_count) == v && int'(h_count) == h) && n < 4 * H_TOTAL) begin
            tick();
            n++;
        end
        if (!(int'(v_count) == v && int'(h_count) == h)) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_h(input int h, input string name);
        int n;
        n = 0;
        while (int'(h_count) != h && n < H_TOTAL + 1) begin
            tick();
            n++;
        end
        if (int'(h_count) != h) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_rk(input int k, input string name);
        int n;
        n = 0;
        while (rk < k && n < 400) begin
            tick();
            n++;
        end
        chk(name, rk, k);
    endtask

    task automatic check_pix(input int h, input int exp_l, input int exp_v, input string name);
        wait_h(h, name);
        chk({name, "_luma"}, donut_luma, exp_l);
        chk({name, "_vis"}, donut_visible, exp_v);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_wr_ready"}, wr_ready, 1);
        chk({name, "_line_req"}, line_req, 0);
        chk({name, "_line_y"}, line_y, 0);
        chk({name, "_luma"}, donut_luma, 0);
        chk({name, "_vis"}, donut_visible, 0);
        chk({name, "_underrun"}, underrun, 0);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < 10; i++)
            check_pix(vecs[i].h, vecs[i].luma, vecs[i].vis, $sformatf("%s%0d", name, i));
    endtask

    initial begin
        // line rendered with tag 0: entry k = k mod 64, shown at h = 8k+1
        vecs[0] = '{h: 1,    luma: 0,  vis: 1};
        vecs[1] = '{h: 8,    luma: 0,  vis: 1};
        vecs[2] = '{h: 9,    luma: 1,  vis: 1};
        vecs[3] = '{h: 505,  luma: 63, vis: 1};
        vecs[4] = '{h: 513,  luma: 0,  vis: 1};
        vecs[5] = '{h: 801,  luma: 36, vis: 1};
        vecs[6] = '{h: 1209, luma: 23, vis: 1};
        vecs[7] = '{h: 1216, luma: 23, vis: 1};
        vecs[8] = '{h: 1217, luma: 23, vis: 0};
        vecs[9] = '{h: 1300, luma: 23, vis: 0};

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
`ifdef LINEBUF_VDOUBLE_EN
        h_count  = 11'd1440;
        v_count  = 10'd8;
`else
        h_count  = 11'd0;
        v_count  = 10'd5;
`endif
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

`ifdef LINEBUF_VDOUBLE_EN
        start_line(0, NPIX);
        // fill straddles the even line end: no swap, no underrun there
        wait_vh(9, 0, "v9_start");
        chk("even_end_underrun", underrun, 0);
        chk("even_end_req", line_req, 0);
        wait_rk(NPIX, "fill_a");
        wait_vh(9, 1524, "v9_end");
        tick();
        chk("odd_swap_req", line_req, 1);
        chk("odd_swap_line_y", line_y, 12);
        start_line(7, NPIX);
        run_table("v10_");
        wait_vh(10, 1524, "v10_end");
        tick();
        chk("even_no_swap_req", line_req, 0);
        check_pix(1, 0, 1, "v11_e0");
        check_pix(41, 5, 1, "v11_e5");
        check_pix(1209, 23, 1, "v11_e151");
        wait_vh(11, 1524, "v11_end");
        tick();
        chk("v11_swap_req", line_req, 1);
        chk("v11_swap_line_y", line_y, 14);
        chk("v12_underrun", underrun, 0);
        check_pix(41, 12, 1, "v12_e5");
`else
        // first line: wr_valid held high beyond one bank
        start_line(0, 200);
        wait_rk(NPIX - 1, "fill_151");
        chk("ready_before_last", wr_ready, 1);
        wait_rk(NPIX, "fill_152");
        chk("ready_drop", wr_ready, 0);
        repeat (5) tick();
        chk("no_beat_when_full", rk, NPIX);
        chk("ready_held_low", wr_ready, 0);
        start_line(5, NPIX);
        check_pix(801, 0, 0, "vis_before_swap");
        wait_vh(5, 1524, "v5_end");
        chk("req_before_swap", line_req, 0);
        tick();
        chk("swap1_req", line_req, 1);
        chk("swap1_line_y", line_y, 7);
        chk("swap1_ready", wr_ready, 1);
        tick();
        chk("req_one_cycle", line_req, 0);

        // v=6 shows tag 0 while tag 5 is rendered
        run_table("v6_");
        wait_vh(6, 1524, "v6_end");
        tick();
        chk("swap2_req", line_req, 1);
        chk("swap2_line_y", line_y, 8);

        // v=7: only 100 beats before the line end
        start_line(9, 100);
        check_pix(41, 10, 1, "v7_e5");
        wait_vh(7, 1524, "v7_end");
        chk("underrun_before", underrun, 0);
        tick();
        chk("underrun_no_req", line_req, 0);
        chk("underrun_set", underrun, 1);
        chk("underrun_ptr", rk, 100);
        chk("underrun_ready", wr_ready, 1);
        rlimit = NPIX;
        drive_src();
        check_pix(41, 10, 1, "repeat_e5");
        check_pix(1209, 28, 1, "repeat_e151");
        wait_vh(8, 1524, "v8_end");
        tick();
        chk("swap3_req", line_req, 1);
        chk("swap3_line_y", line_y, 10);
        chk("underrun_sticky", underrun, 1);

        // v=9: shows resumed line; next line's final beat held to the line end
        start_line(20, NPIX);
        rhold = 1'b1;
        drive_src();
        check_pix(793, 44, 1, "resume_e99");
        check_pix(801, 45, 1, "resume_e100");
        wait_vh(9, 1523, "v9_hold");
        chk("hold_ptr", rk, NPIX - 1);
        chk("hold_ready", wr_ready, 1);
        tick();
        chk("hold_valid_at_swap", wr_valid, 1);
        tick();
        rhold = 1'b0;
        chk("coinc_beat", rk, NPIX);
        chk("coinc_req", line_req, 1);
        chk("coinc_line_y", line_y, 11);
        chk("coinc_ready", wr_ready, 1);
        check_pix(1201, 42, 1, "coinc_e150");
        check_pix(1209, 43, 1, "coinc_e151");

        // reset in the middle of a fill
        start_line(33, NPIX);
        wait_rk(70, "partial_70");
        rst      = 1'b1;
        wr_valid = 1'b0;
        tick();
        check_reset_outputs("midfill_rst");
        rst = 1'b0;
        start_line(40, NPIX);
        wait_vh(10, 1500, "v10_late");
        chk("vis_after_rst", donut_visible, 0);
        wait_vh(10, 1524, "v10_end");
        chk("rst_no_early_req", line_req, 0);
        tick();
        chk("swap_after_rst_req", line_req, 1);
        chk("swap_after_rst_line_y", line_y, 12);
        check_pix(1, 40, 1, "after_rst_e0");
        check_pix(561, 46, 1, "after_rst_e70");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
